qerv_rf_ram_if: RTL and testbench

- Responder end of the core's RF request interface.
- Accepts single-cycle read/write pass requests from the state controller and answers with a one-cycle o_ready strobe.
- During the following 32/W-cycle pass it streams two source operands out as W-bit beats, LSB first, and collects two W-bit write streams.
- Packs beats into 2*W-bit words for a simple dual-port RAM (independent read and write ports, 1-cycle registered read latency) that holds 32 GPRs plus CSR_REGS CSR-backing registers.

---
 rtl/qerv_rf_ram_if.sv | 170 +++++++++++++++++
 tb/tb_qerv_rf_ram_if.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/qerv_rf_ram_if.sv
// Serial register-file front end: streams two W-bit read operands and packs two
// W-bit write streams into 2*W-bit words of a simple dual-port RAM (1-cycle read).
module qerv_rf_ram_if #(
   parameter int W        = 4,
   parameter int CSR_REGS = 4,
   localparam int DW  = 2 * W,
   localparam int WPR = 16 / W,
   localparam int N   = 32 / W,
   localparam int RW  = $clog2(32 + CSR_REGS),
   localparam int WB  = $clog2(WPR),
   localparam int AW  = RW + WB,
   localparam int NW  = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_rreq,
   input  logic          i_wreq,
   output logic          o_ready,
   input  logic [RW-1:0] i_rreg0,
   input  logic [RW-1:0] i_rreg1,
   output logic [W-1:0]  o_rdata0,
   output logic [W-1:0]  o_rdata1,
   input  logic [RW-1:0] i_wreg0,
   input  logic [RW-1:0] i_wreg1,
   input  logic          i_wen0,
   input  logic          i_wen1,
   input  logic [W-1:0]  i_wdata0,
   input  logic [W-1:0]  i_wdata1,
   output logic [AW-1:0] o_waddr,
   output logic [DW-1:0] o_wdata,
   output logic          o_wen,
   output logic [AW-1:0] o_raddr,
   output logic          o_ren,
   input  logic [DW-1:0] i_rdata
);

   // Handshake: a request strobe is honoured only in IDLE; o_ready is a single-cycle
   // strobe and beat 0 of the pass is presented in the cycle right after it.
   typedef enum logic [1:0] {IDLE, PRIME, READY, PASS} state_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   bcnt_q;
   logic [NW-1:0]   rcnt_q;
   logic            ract_q;
   logic            rmode_q;
   logic [RW-1:0]   rreg0_q, rreg1_q;
   logic            rvld_q, rport_q;
   logic [DW-1:0]   buf0_q;
   logic [W-1:0]    buf1_hi_q;
   logic [W-1:0]    lo0_q, lo1_q;
   logic [DW-1:0]   hold1_q;
   logic [AW-1:0]   hold1_addr_q;
   logic            hold1_v_q;
   logic            load;
   logic            nb_odd;
   logic [W-1:0]    rd0_d, rd1_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_rreq) state_d = PRIME;
                  else if (i_wreq) state_d = READY;
         PRIME:   if (rcnt_q == NW'(1)) state_d = READY;
         READY:   state_d = PASS;
         PASS:    if (bcnt_q == NW'(N - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign o_ready = (state_q == READY);

   // Reads alternate port0/port1, word-major, one per cycle from the cycle after the request.
   assign o_ren   = ract_q;
   assign o_raddr = {(rcnt_q[0] ? rreg1_q : rreg0_q), rcnt_q[NW-1:1]};

   assign load   = rmode_q && ((state_q == READY) ||
                               ((state_q == PASS) && (bcnt_q != NW'(N - 1))));
   assign nb_odd = (state_q == PASS) && !bcnt_q[0];

   // Port 1's word arrives exactly when its low beat is due, so it bypasses the buffer.
   always_comb begin
      rd0_d = '0;
      rd1_d = '0;
      if (load) begin
         if (nb_odd) begin
            rd0_d = buf0_q[DW-1:W];
            rd1_d = buf1_hi_q;
         end else begin
            rd0_d = buf0_q[W-1:0];
            rd1_d = i_rdata[W-1:0];
         end
      end
      if (!(|rreg0_q)) rd0_d = '0;
      if (!(|rreg1_q)) rd1_d = '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         bcnt_q       <= '0;
         rcnt_q       <= '0;
         ract_q       <= 1'b0;
         rmode_q      <= 1'b0;
         rreg0_q      <= '0;
         rreg1_q      <= '0;
         rvld_q       <= 1'b0;
         rport_q      <= 1'b0;
         buf0_q       <= '0;
         buf1_hi_q    <= '0;
         lo0_q        <= '0;
         lo1_q        <= '0;
         hold1_q      <= '0;
         hold1_addr_q <= '0;
         hold1_v_q    <= 1'b0;
         o_rdata0     <= '0;
         o_rdata1     <= '0;
         o_wen        <= 1'b0;
         o_waddr      <= '0;
         o_wdata      <= '0;
      end else begin
         state_q <= state_d;

         if (state_q == IDLE && i_rreq) begin
            ract_q  <= 1'b1;
            rcnt_q  <= '0;
            rmode_q <= 1'b1;
            rreg0_q <= i_rreg0;
            rreg1_q <= i_rreg1;
         end else if (state_q == IDLE && i_wreq) begin
            rmode_q <= 1'b0;
         end else if (ract_q) begin
            rcnt_q <= rcnt_q + NW'(1);
            if (rcnt_q == NW'(N - 1)) ract_q <= 1'b0;
         end

         rvld_q  <= ract_q;
         rport_q <= rcnt_q[0];
         if (rvld_q && !rport_q) buf0_q    <= i_rdata;
         if (rvld_q && rport_q)  buf1_hi_q <= i_rdata[DW-1:W];

         o_rdata0 <= rd0_d;
         o_rdata1 <= rd1_d;

         bcnt_q <= (state_q == PASS) ? bcnt_q + NW'(1) : '0;

         // Port 0 writes straight after its odd beat; port 1 waits one cycle in hold1.
         o_wen <= 1'b0;
         if (state_q == PASS) begin
            if (!bcnt_q[0]) begin
               lo0_q <= i_wdata0;
               lo1_q <= i_wdata1;
            end else begin
               o_wen        <= i_wen0 && (|i_wreg0);
               o_waddr      <= {i_wreg0, bcnt_q[NW-1:1]};
               o_wdata      <= {i_wdata0, lo0_q};
               hold1_q      <= {i_wdata1, lo1_q};
               hold1_addr_q <= {i_wreg1, bcnt_q[NW-1:1]};
               hold1_v_q    <= i_wen1 && (|i_wreg1);
            end
         end
         if (hold1_v_q) begin
            o_wen     <= 1'b1;
            o_waddr   <= hold1_addr_q;
            o_wdata   <= hold1_q;
            hold1_v_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_qerv_rf_ram_if.sv
// Directed bench for qerv_rf_ram_if with a behavioural dual-port RAM and a
// cycle-stamped scoreboard of expected RAM writes.
module tb_qerv_rf_ram_if;

   localparam int W        = 4;
   localparam int CSR_REGS = 4;
   localparam int DW       = 8;
   localparam int N        = 8;
   localparam int WPR      = 4;
   localparam int RW       = 6;
   localparam int WB       = 2;
   localparam int AW       = 8;

   logic          i_clk;
   logic          i_rst;
   logic          i_rreq, i_wreq;
   logic          o_ready;
   logic [RW-1:0] i_rreg0, i_rreg1;
   logic [W-1:0]  o_rdata0, o_rdata1;
   logic [RW-1:0] i_wreg0, i_wreg1;
   logic          i_wen0, i_wen1;
   logic [W-1:0]  i_wdata0, i_wdata1;
   logic [AW-1:0] o_waddr;
   logic [DW-1:0] o_wdata;
   logic          o_wen;
   logic [AW-1:0] o_raddr;
   logic          o_ren;
   logic [DW-1:0] i_rdata;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // {cycle[15:0], addr, data}
   logic [31:0] exp_q[$];

   qerv_rf_ram_if #(.W(W), .CSR_REGS(CSR_REGS)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rreq(i_rreq), .i_wreq(i_wreq), .o_ready(o_ready),
      .i_rreg0(i_rreg0), .i_rreg1(i_rreg1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
      .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
      .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .o_waddr(o_waddr), .o_wdata(o_wdata),
      .o_wen(o_wen), .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   always @(posedge i_clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (o_wen) mem[o_waddr] <= o_wdata;
      if (o_ren) i_rdata <= mem[o_raddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // scoreboard: every RAM write must match the head of exp_q in cycle, address and data
   always @(negedge i_clk) begin
      if (o_wen) begin
         check("wr_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            check("wr", {16'(cyc), o_waddr, o_wdata}, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
      if (exp_q.size() != 0 && int'(exp_q[0][31:16]) < cyc) begin
         check("wr_missed", 32'(cyc), 32'(exp_q[0][31:16]));
         void'(exp_q.pop_front());
      end
   end

   // driver tasks
   task automatic preload(input int a, input logic [DW-1:0] d);
      pre_en = 1'b1; pre_addr = AW'(a); pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic start_pass(input logic rq, input logic wq, input logic [RW-1:0] r0,
                             input logic [RW-1:0] r1, input int lat, input string tag);
      check({tag, "_ready_t0"}, 32'(o_ready), 0);
      i_rreq = rq; i_wreq = wq; i_rreg0 = r0; i_rreg1 = r1;
      tick();
      i_rreq = 1'b0; i_wreq = 1'b0; i_rreg0 = ~r0; i_rreg1 = ~r1;
      for (int i = 1; i <= lat; i++) begin
         check({tag, "_ready"}, 32'(o_ready), 32'(i == lat));
         tick();
      end
   endtask

   task automatic beats(input logic rd, input logic [RW-1:0] w0, input logic [RW-1:0] w1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic e0, input logic e1,
                        input logic [31:0] x0, input logic [31:0] x1,
                        input int rst_at, input int poke_at);
      int tp;
      tp = cyc;
      i_wreg0 = w0; i_wreg1 = w1;
      for (int j = 0; j < WPR; j++) begin
         if (e0 && w0 != 0) exp_q.push_back({16'(tp + 2*j + 2), w0, WB'(j), d0[DW*j +: DW]});
         if (e1 && w1 != 0) exp_q.push_back({16'(tp + 2*j + 3), w1, WB'(j), d1[DW*j +: DW]});
      end
      for (int k = 0; k < N; k++) begin
         i_wdata0 = d0[W*k +: W]; i_wdata1 = d1[W*k +: W];
         i_wen0 = e0; i_wen1 = e1;
         i_rreq = (k == poke_at); i_wreq = (k == poke_at);
         check("rdata0", 32'(o_rdata0), rd ? 32'(x0[W*k +: W]) : 32'd0);
         check("rdata1", 32'(o_rdata1), rd ? 32'(x1[W*k +: W]) : 32'd0);
         check("ready_busy", 32'(o_ready), 0);
         if (k == rst_at) begin
            i_rst = 1'b1;
            while (exp_q.size() != 0 && int'(exp_q[exp_q.size()-1][31:16]) > cyc)
               void'(exp_q.pop_back());
            tick();
            i_rst = 1'b0; i_wen0 = 1'b0; i_wen1 = 1'b0; i_rreq = 1'b0; i_wreq = 1'b0;
            return;
         end
         tick();
      end
      i_wen0 = 1'b0; i_wen1 = 1'b0; i_rreq = 1'b0; i_wreq = 1'b0;
      i_wdata0 = '0; i_wdata1 = '0;
      check("rdata0_idle", 32'(o_rdata0), 0);
      check("rdata1_idle", 32'(o_rdata1), 0);
   endtask

   initial begin
      i_rst = 1'b1; i_rreq = 1'b0; i_wreq = 1'b0;
      i_rreg0 = '0; i_rreg1 = '0; i_wreg0 = '0; i_wreg1 = '0;
      i_wen0 = 1'b0; i_wen1 = 1'b0; i_wdata0 = '0; i_wdata1 = '0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      repeat (3) tick();
      i_rst = 1'b0;

      check("rst_ready", 32'(o_ready), 0);
      check("rst_wen", 32'(o_wen), 0);
      check("rst_ren", 32'(o_ren), 0);
      check("rst_rdata0", 32'(o_rdata0), 0);
      check("rst_rdata1", 32'(o_rdata1), 0);
      tick();

      // write x5 = DEADBEEF, then read it back with x0 on port 1
      start_pass(1'b0, 1'b1, '0, '0, 1, "t1w");
      beats(1'b0, 6'd5, 6'd7, 32'hDEADBEEF, 32'h11111111, 1'b1, 1'b0, 0, 0, -1, -1);
      start_pass(1'b1, 1'b0, 6'd5, 6'd0, 3, "t1r");
      beats(1'b1, '0, '0, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, -1, -1);

      // dual write x1 and reg 33 in one pass, then read both
      start_pass(1'b0, 1'b1, '0, '0, 1, "t2w");
      beats(1'b0, 6'd1, 6'd33, 32'h12345678, 32'hCAFEF00D, 1'b1, 1'b1, 0, 0, -1, -1);
      start_pass(1'b1, 1'b0, 6'd1, 6'd33, 3, "t2r");
      beats(1'b1, '0, '0, 0, 0, 1'b0, 1'b0, 32'h12345678, 32'hCAFEF00D, -1, -1);

      // x0 write and disabled port 1 over preloaded words
      repeat (2) tick();
      for (int a = 0; a < 4; a++) preload(a, 8'hFF);
      for (int a = 8; a < 12; a++) preload(a, 8'hFF);
      start_pass(1'b0, 1'b1, '0, '0, 1, "t3w");
      beats(1'b0, 6'd0, 6'd2, 32'h55555555, 32'hAAAAAAAA, 1'b1, 1'b0, 0, 0, -1, -1);
      start_pass(1'b1, 1'b0, 6'd0, 6'd2, 3, "t3r");
      beats(1'b1, '0, '0, 0, 0, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, -1, -1);

      // simultaneous strobes, plus strobes while busy
      start_pass(1'b1, 1'b1, 6'd5, 6'd1, 3, "t4");
      beats(1'b1, 6'd3, 6'd34, 32'h0F1E2D3C, 32'h89ABCDEF, 1'b1, 1'b1,
            32'hDEADBEEF, 32'h12345678, -1, 2);

      // reset at beat 3 of a write pass
      start_pass(1'b0, 1'b1, '0, '0, 1, "t5w");
      beats(1'b0, 6'd6, 6'd35, 32'h01234567, 32'h76543210, 1'b1, 1'b1, 0, 0, 3, -1);
      check("t5_wen_a", 32'(o_wen), 0);
      check("t5_ready_a", 32'(o_ready), 0);
      tick();
      check("t5_wen_b", 32'(o_wen), 0);
      check("t5_ready_b", 32'(o_ready), 0);

      // back-to-back write passes, then read everything back
      start_pass(1'b0, 1'b1, '0, '0, 1, "t6a");
      beats(1'b0, 6'd8, 6'd9, 32'h13579BDF, 32'h2468ACE0, 1'b1, 1'b1, 0, 0, -1, -1);
      start_pass(1'b0, 1'b1, '0, '0, 1, "t6b");
      beats(1'b0, 6'd10, 6'd11, 32'hFEDCBA98, 32'h0BADF00D, 1'b1, 1'b1, 0, 0, -1, -1);
      start_pass(1'b1, 1'b0, 6'd9, 6'd11, 3, "t6r1");
      beats(1'b1, '0, '0, 0, 0, 1'b0, 1'b0, 32'h2468ACE0, 32'h0BADF00D, -1, -1);
      start_pass(1'b1, 1'b0, 6'd8, 6'd10, 3, "t6r2");
      beats(1'b1, '0, '0, 0, 0, 1'b0, 1'b0, 32'h13579BDF, 32'hFEDCBA98, -1, -1);
      start_pass(1'b1, 1'b0, 6'd3, 6'd34, 3, "t4r");
      beats(1'b1, '0, '0, 0, 0, 1'b0, 1'b0, 32'h0F1E2D3C, 32'h89ABCDEF, -1, -1);

      // final report
      repeat (4) tick();
      check("exp_q_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
